floating_point_control: RTL and testbench
=========================================

// Module: floating_point_control
// PURPOSE
//  Sequencer FSM that drives the floating_point datapath control inputs (muxes, shifters, big/small ALU) for FP add/sub and mul.
//  Takes datapath status flags and produces, cycle by cycle, the control words the datapath consumes. Host sees start/busy/done.
//  Sits between the CPU FP issue logic and floating_point.
// PARAMETERS
//  MUL_TIMEOUT  64  max cycles in MUL_RUN before abort (used only with FP_CTRL_TIMEOUT_EN)
//  MAX_ALIGN    26  saturation value for controlShiftRight (larger shifts zero the mantissa)
// PORTS
//  clk                          in   1   clock, rising edge
//  reset                        in   1   asynchronous, active-low reset
//  start                        in   1   request; sampled only in IDLE
//  op                           in   1   0 = add/sub, 1 = mul; latched with start
//  sign1, sign2                 in   1   operand signs
//  expDiffNeg                   in   1   small-ALU result sign (exp1 < exp2)
//  expDiff                      in   8   |exp1 - exp2| from small ALU
//  carryOut                     in   1   big-ALU mantissa overflow
//  lzc                          in   5   leading-zero count of big-ALU result
//  mantZero                     in   1   big-ALU result is zero
//  multDone                     in   1   multiplier finished (finalizeOperation)
//  roundOverflow                in   1   rounder carried out of the mantissa
//  busy / done / error          out  1   op in flight / 1-cycle completion pulse / timeout abort
//  controlToMux01..05           out  1   datapath mux selects
//  controlShiftRight            out  8   alignment shift amount
//  controlToIncreaseOrDecrease  out  4   exponent inc/dec opcode
//  IncreaseOrDecreaseEnable     out  1   exponent adjust enable
//  howManyToIncreaseOrDecrease  out  8   exponent adjust amount
//  rightOrLeft                  out  1   normalize direction, 1 = right
//  howMany                      out  23  normalize shift amount
//  isSum, sum_sub               out  1   big-ALU add mode / subtract
//  aluReset                     out  1   big-ALU reset (datapath 'reset' input)
//  muxDataRegValor2             out  1   multiplier data-register select
//  smallALUOperation            out  4   small-ALU opcode
//  muxAControlSmall, muxBControlSmall, loadRegSmall  out  1   small-ALU operand selects / result load
// BEHAVIOUR
//  Reset
//   - State = IDLE; every output 0; latched op/signs cleared.
//   - reset low mid-operation aborts immediately. done is not pulsed.
//  Handshake
//   - start && IDLE: latch op, sign1, sign2; busy = 1 from the next cycle until the DONE cycle inclusive.
//   - start is ignored while busy.
//  Add path (all outputs are Moore, decoded from registered state + latched status)
//   - EXP_CMP: smallALUOperation = SUB; muxA/B = 0; loadRegSmall = 1.
//   - ALIGN: if expDiffNeg then mux01 = 1, mux03 = 0, mux04 = 1; else mux01 = 0, mux03 = 1, mux04 = 0.
//     controlShiftRight = min(expDiff, MAX_ALIGN).
//   - ADD: isSum = 1; sum_sub = sign1 ^ sign2.
//   - NORMALIZE, first matching case wins:
//     - mantZero: go straight to DONE.
//     - carryOut: rightOrLeft = 1, howMany = 1, exp INC by 1.
//     - lzc > 0: rightOrLeft = 0, howMany = lzc, exp DEC by lzc.
//     - otherwise: no change.
//   - ROUND: if roundOverflow go to RENORM, else DONE.
//   - RENORM: mux02 = mux05 = 1; shift right by 1; exp INC by 1.
//  Mul path
//   - MUL_INIT (exactly 1 cycle): aluReset = 1; muxA/B = 1; smallALUOperation = ADD; loadRegSmall = 1; muxDataRegValor2 = 0.
//   - MUL_RUN: aluReset = 0; isSum = 0; muxDataRegValor2 = 1. Held until multDone, then NORMALIZE -> ROUND as in the add path.
//  DONE: done = 1 for 1 cycle, then IDLE.
//  Latency from the start edge to done: add = 6 cycles; add with RENORM = 7; mul = 4 + MUL_RUN cycles.
//  Simultaneous carryOut and lzc > 0: carryOut wins.
// CONFIGURATION
//  FP_CTRL_TIMEOUT_EN
//   - Defined: a counter runs in MUL_RUN. At MUL_TIMEOUT cycles without multDone, go to DONE with error = 1 for the done cycle.
//   - Undefined: MUL_RUN waits indefinitely; error is tied to 0; no counter is instantiated.
// STRUCTURE
//  fp_ctrl_pkg: state enum (IDLE, EXP_CMP, ALIGN, ADD, MUL_INIT, MUL_RUN, NORMALIZE, ROUND, RENORM, DONE);
//   SMALL_OP_ADD = 4'b0000, SMALL_OP_SUB = 4'b0011; EXP_INC = 4'b0000, EXP_DEC = 4'b0001.
//  Sub-module fp_ctrl_cycle_counter: the timeout counter, only under the macro.
// TESTING
//  1. Add 0x3F400000 + 0x40100000 (expDiffNeg = 1, expDiff = 2) -> ALIGN: mux01 = 1, mux04 = 1, shiftRight = 2; done at +6; result 0x40400000.
//  2. Add 0x41FC0000 + 0xC0880000 -> sum_sub = 1, mux03 = 1, shiftRight = 2; result 0x41DA0000.
//  3. Mul 0x40561B86 * 0x3EC28F5C -> aluReset high exactly 1 cycle; muxDataRegValor2 = 1 until multDone; result 0x3FA2B8C2.
//  4. Add 0x401FFFFF + 0x3FC00001 with roundOverflow = 1 -> RENORM: mux02 = mux05 = 1, right 1, exp +1; done at +7; result 0x40800000.
//  5. reset low during MUL_RUN -> all outputs 0 asynchronously, busy = 0, no done; next start is accepted normally.
//  6. FP_CTRL_TIMEOUT_EN with multDone held at 0 -> done = error = 1 after MUL_TIMEOUT cycles in MUL_RUN.

Source files
------------

// File: rtl/fp_ctrl_pkg.sv
// Shared types for the floating_point datapath sequencer: state encoding, opcodes
// and the registered control word driven onto the datapath.
package fp_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE, EXP_CMP, ALIGN, ADD, MUL_INIT, MUL_RUN, NORMALIZE, ROUND, RENORM, DONE
    } state_t;

    localparam logic [3:0] SMALL_OP_ADD = 4'b0000;
    localparam logic [3:0] SMALL_OP_SUB = 4'b0011;
    localparam logic [3:0] EXP_INC      = 4'b0000;
    localparam logic [3:0] EXP_DEC      = 4'b0001;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        error;
        logic [5:1]  mux;
        logic [7:0]  shiftRight;
        logic [3:0]  incDecOp;
        logic        incDecEn;
        logic [7:0]  incDecAmt;
        logic        rightOrLeft;
        logic [22:0] howMany;
        logic        isSum;
        logic        sumSub;
        logic        aluReset;
        logic        muxDataRegValor2;
        logic [3:0]  smallOp;
        logic        muxASmall;
        logic        muxBSmall;
        logic        loadRegSmall;
    } ctrl_t;

endpackage

// File: rtl/fp_ctrl_cycle_counter.sv
// MUL_RUN watchdog: counts cycles while enabled, flags the last allowed cycle.
// Only instantiated when FP_CTRL_TIMEOUT_EN is defined.
module fp_ctrl_cycle_counter #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic expire
);
    localparam int W = $clog2(LIMIT) + 1;

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       count <= '0;
        else if (!en)     count <= '0;
        else if (!expire) count <= count + W'(1);
    end

    // count is 0 in the first enabled cycle, so this marks the LIMIT-th cycle
    assign expire = en && (count == W'(LIMIT - 1));

endmodule

// File: rtl/floating_point_control.sv
// Sequencer for the floating_point datapath (add/sub and mul). Control word is
// registered: decoded from the next state at each edge. Optional FP_CTRL_TIMEOUT_EN.
module floating_point_control
    import fp_ctrl_pkg::*;
#(
    parameter int MUL_TIMEOUT = 64,
    parameter int MAX_ALIGN   = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic        sign1,
    input  logic        sign2,
    input  logic        expDiffNeg,
    input  logic [7:0]  expDiff,
    input  logic        carryOut,
    input  logic [4:0]  lzc,
    input  logic        mantZero,
    input  logic        multDone,
    input  logic        roundOverflow,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        controlToMux01,
    output logic        controlToMux02,
    output logic        controlToMux03,
    output logic        controlToMux04,
    output logic        controlToMux05,
    output logic [7:0]  controlShiftRight,
    output logic [3:0]  controlToIncreaseOrDecrease,
    output logic        IncreaseOrDecreaseEnable,
    output logic [7:0]  howManyToIncreaseOrDecrease,
    output logic        rightOrLeft,
    output logic [22:0] howMany,
    output logic        isSum,
    output logic        sum_sub,
    output logic        aluReset,
    output logic        muxDataRegValor2,
    output logic [3:0]  smallALUOperation,
    output logic        muxAControlSmall,
    output logic        muxBControlSmall,
    output logic        loadRegSmall
);
    state_t state, nxt;
    ctrl_t  ctrl, nxtCtrl;
    logic   sign1Lat, sign2Lat, zeroLat;
    logic   timeoutHit;

`ifdef FP_CTRL_TIMEOUT_EN
    fp_ctrl_cycle_counter #(.LIMIT(MUL_TIMEOUT)) uTimeout (
        .clk    (clk),
        .reset  (reset),
        .en     (state == MUL_RUN),
        .expire (timeoutHit)
    );
`else
    // MUL_RUN waits for multDone indefinitely in this build
    assign timeoutHit = 1'b0 & (MUL_TIMEOUT > 0);
`endif

    always_comb begin
        nxt     = state;
        nxtCtrl = '0;
        case (state)
            IDLE:      if (start) nxt = op ? MUL_INIT : EXP_CMP;
            EXP_CMP:   nxt = ALIGN;
            ALIGN:     nxt = ADD;
            ADD:       nxt = NORMALIZE;
            MUL_INIT:  nxt = MUL_RUN;
            MUL_RUN:   if (multDone) nxt = NORMALIZE;
                       else if (timeoutHit) nxt = DONE;
            NORMALIZE: nxt = zeroLat ? DONE : ROUND;
            ROUND:     nxt = roundOverflow ? RENORM : DONE;
            RENORM:    nxt = DONE;
            DONE:      nxt = IDLE;
            default:   nxt = IDLE;
        endcase

        nxtCtrl.busy = (nxt != IDLE);
        case (nxt)
            EXP_CMP: begin
                nxtCtrl.smallOp      = SMALL_OP_SUB;
                nxtCtrl.loadRegSmall = 1'b1;
            end
            ALIGN: begin
                nxtCtrl.mux[1]     = expDiffNeg;
                nxtCtrl.mux[3]     = !expDiffNeg;
                nxtCtrl.mux[4]     = expDiffNeg;
                nxtCtrl.shiftRight = (expDiff > 8'(MAX_ALIGN)) ? 8'(MAX_ALIGN) : expDiff;
            end
            ADD: begin
                nxtCtrl.isSum  = 1'b1;
                nxtCtrl.sumSub = sign1Lat ^ sign2Lat;
            end
            MUL_INIT: begin
                nxtCtrl.aluReset     = 1'b1;
                nxtCtrl.muxASmall    = 1'b1;
                nxtCtrl.muxBSmall    = 1'b1;
                nxtCtrl.smallOp      = SMALL_OP_ADD;
                nxtCtrl.loadRegSmall = 1'b1;
            end
            MUL_RUN: nxtCtrl.muxDataRegValor2 = 1'b1;
            NORMALIZE: begin
                // carryOut has priority over a leading-zero left shift
                if (!mantZero && carryOut) begin
                    nxtCtrl.rightOrLeft = 1'b1;
                    nxtCtrl.howMany     = 23'd1;
                    nxtCtrl.incDecEn    = 1'b1;
                    nxtCtrl.incDecOp    = EXP_INC;
                    nxtCtrl.incDecAmt   = 8'd1;
                end else if (!mantZero && lzc != 5'd0) begin
                    nxtCtrl.howMany   = 23'(lzc);
                    nxtCtrl.incDecEn  = 1'b1;
                    nxtCtrl.incDecOp  = EXP_DEC;
                    nxtCtrl.incDecAmt = 8'(lzc);
                end
            end
            RENORM: begin
                nxtCtrl.mux[2]      = 1'b1;
                nxtCtrl.mux[5]      = 1'b1;
                nxtCtrl.rightOrLeft = 1'b1;
                nxtCtrl.howMany     = 23'd1;
                nxtCtrl.incDecEn    = 1'b1;
                nxtCtrl.incDecOp    = EXP_INC;
                nxtCtrl.incDecAmt   = 8'd1;
            end
            DONE: begin
                nxtCtrl.done  = 1'b1;
                nxtCtrl.error = (state == MUL_RUN) && !multDone && timeoutHit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ctrl     <= '0;
            sign1Lat <= 1'b0;
            sign2Lat <= 1'b0;
            zeroLat  <= 1'b0;
        end else begin
            state <= nxt;
            ctrl  <= nxtCtrl;
            if (state == IDLE && start) begin
                sign1Lat <= sign1;
                sign2Lat <= sign2;
            end
            if (nxt == NORMALIZE) zeroLat <= mantZero;
        end
    end

    assign busy                        = ctrl.busy;
    assign done                        = ctrl.done;
    assign error                       = ctrl.error;
    assign controlToMux01              = ctrl.mux[1];
    assign controlToMux02              = ctrl.mux[2];
    assign controlToMux03              = ctrl.mux[3];
    assign controlToMux04              = ctrl.mux[4];
    assign controlToMux05              = ctrl.mux[5];
    assign controlShiftRight           = ctrl.shiftRight;
    assign controlToIncreaseOrDecrease = ctrl.incDecOp;
    assign IncreaseOrDecreaseEnable    = ctrl.incDecEn;
    assign howManyToIncreaseOrDecrease = ctrl.incDecAmt;
    assign rightOrLeft                 = ctrl.rightOrLeft;
    assign howMany                     = ctrl.howMany;
    assign isSum                       = ctrl.isSum;
    assign sum_sub                     = ctrl.sumSub;
    assign aluReset                    = ctrl.aluReset;
    assign muxDataRegValor2            = ctrl.muxDataRegValor2;
    assign smallALUOperation           = ctrl.smallOp;
    assign muxAControlSmall            = ctrl.muxASmall;
    assign muxBControlSmall            = ctrl.muxBSmall;
    assign loadRegSmall                = ctrl.loadRegSmall;

endmodule

// File: tb/tb_floating_point_control.sv
// Bench for floating_point_control: per-cycle control-word checks against a list of
// expected records built from the operation's phase rules; directed plus random ops.
module tb_floating_point_control;

    localparam int TIMEOUT = 64;

    logic clk = 1'b0, reset = 1'b0;
    logic start = 0, op = 0, sign1 = 0, sign2 = 0, expDiffNeg = 0, carryOut = 0;
    logic mantZero = 0, multDone = 0, roundOverflow = 0;
    logic [7:0] expDiff = '0;
    logic [4:0] lzc = '0;
    logic busy, done, error, m1, m2, m3, m4, m5, incDecEn, rol, isSum, sumSub, aluRst, mdr2;
    logic muxA, muxB, loadSmall;
    logic [7:0] shr, incDecAmt;
    logic [3:0] incDecOp, smallOp;
    logic [22:0] howMany;

    typedef struct packed {
        logic busy, done, error, m1, m2, m3, m4, m5;
        logic [7:0] shr;
        logic [3:0] incDecOp;
        logic incDecEn;
        logic [7:0] incDecAmt;
        logic rol;
        logic [22:0] howMany;
        logic isSum, sumSub, aluRst, mdr2;
        logic [3:0] smallOp;
        logic muxA, muxB, loadSmall;
    } rec_t;

    int nCmp = 0, nFail = 0;

    floating_point_control #(.MUL_TIMEOUT(TIMEOUT), .MAX_ALIGN(26)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .sign1(sign1), .sign2(sign2),
        .expDiffNeg(expDiffNeg), .expDiff(expDiff), .carryOut(carryOut), .lzc(lzc),
        .mantZero(mantZero), .multDone(multDone), .roundOverflow(roundOverflow),
        .busy(busy), .done(done), .error(error),
        .controlToMux01(m1), .controlToMux02(m2), .controlToMux03(m3),
        .controlToMux04(m4), .controlToMux05(m5), .controlShiftRight(shr),
        .controlToIncreaseOrDecrease(incDecOp), .IncreaseOrDecreaseEnable(incDecEn),
        .howManyToIncreaseOrDecrease(incDecAmt), .rightOrLeft(rol), .howMany(howMany),
        .isSum(isSum), .sum_sub(sumSub), .aluReset(aluRst), .muxDataRegValor2(mdr2),
        .smallALUOperation(smallOp), .muxAControlSmall(muxA), .muxBControlSmall(muxB),
        .loadRegSmall(loadSmall)
    );

    always #5 clk = ~clk;

    function automatic rec_t observe();
        rec_t r;
        r = '{busy, done, error, m1, m2, m3, m4, m5, shr, incDecOp, incDecEn, incDecAmt,
              rol, howMany, isSum, sumSub, aluRst, mdr2, smallOp, muxA, muxB, loadSmall};
        return r;
    endfunction

    task automatic check(input string tag, input rec_t expv);
        rec_t obs;
        obs = observe();
        nCmp++;
        assert (obs === expv) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Builds the expected cycle-by-cycle control words of one operation, then drives it.
    task automatic runTxn(input string tag, input bit isMul, input bit s1, input bit s2,
                          input bit neg, input logic [7:0] diff, input bit co,
                          input logic [4:0] lz, input bit mz, input bit rovf,
                          input int n, input bit hang);
        rec_t q[$];
        rec_t base, r;
        int len;
        base = '0;
        base.busy = 1'b1;
        if (!isMul) begin
            r = base; r.smallOp = 4'b0011; r.loadSmall = 1; q.push_back(r);
            r = base;
            if (neg) begin r.m1 = 1; r.m4 = 1; end else r.m3 = 1;
            r.shr = (diff > 8'd26) ? 8'd26 : diff;
            q.push_back(r);
            r = base; r.isSum = 1; r.sumSub = s1 ^ s2; q.push_back(r);
        end else begin
            r = base; r.aluRst = 1; r.muxA = 1; r.muxB = 1; r.smallOp = 4'b0000; r.loadSmall = 1;
            q.push_back(r);
            for (int i = 0; i < (hang ? TIMEOUT : n); i++) begin
                r = base; r.mdr2 = 1; q.push_back(r);
            end
        end
        if (!hang) begin
            r = base;
            if (!mz && co) begin
                r.rol = 1; r.howMany = 23'd1; r.incDecEn = 1; r.incDecOp = 4'b0000; r.incDecAmt = 8'd1;
            end else if (!mz && lz != 0) begin
                r.rol = 0; r.howMany = 23'(lz); r.incDecEn = 1; r.incDecOp = 4'b0001;
                r.incDecAmt = 8'(lz);
            end
            q.push_back(r);
            if (!mz) begin
                q.push_back(base);
                if (rovf) begin
                    r = base; r.m2 = 1; r.m5 = 1; r.rol = 1; r.howMany = 23'd1;
                    r.incDecEn = 1; r.incDecOp = 4'b0000; r.incDecAmt = 8'd1;
                    q.push_back(r);
                end
            end
        end
        r = base; r.done = 1; r.error = hang; q.push_back(r);
        q.push_back('0);
        len = q.size() - 1;  // cycle index of the done pulse

        @(negedge clk);
        op = isMul; sign1 = s1; sign2 = s2; expDiffNeg = neg; expDiff = diff; carryOut = co;
        lzc = lz; mantZero = mz; roundOverflow = rovf; multDone = 0; start = 1;
        for (int c = 1; c <= q.size(); c++) begin
            @(negedge clk);
            check($sformatf("%s_c%0d", tag, c), q[c-1]);
            // start/op/sign noise while busy must not disturb the running op
            start = (c <= len) ? 1'($urandom_range(0, 1)) : 1'b0;
            op    = 1'($urandom_range(0, 1));
            sign1 = 1'($urandom_range(0, 1));
            sign2 = 1'($urandom_range(0, 1));
            multDone = isMul && !hang && (c >= n + 1) && (c <= len);
        end
        start = 0; multDone = 0;
    endtask

    initial begin
        rec_t zero;
        zero = '0;
        repeat (2) @(negedge clk);
        check("reset_state", zero);
        reset = 1;
        @(negedge clk);
        check("idle_after_reset", zero);

        runTxn("t1_add_neg",  0, 0, 0, 1, 8'd2,   0, 5'd0, 0, 0, 0, 0);
        runTxn("t2_sub",      0, 0, 1, 0, 8'd2,   0, 5'd1, 0, 0, 0, 0);
        runTxn("t3_mul",      1, 0, 0, 0, 8'd0,   0, 5'd1, 0, 0, 5, 0);
        runTxn("t4_renorm",   0, 0, 0, 0, 8'd1,   1, 5'd0, 0, 1, 0, 0);
        runTxn("sat26",       0, 1, 1, 0, 8'd26,  0, 5'd3, 0, 0, 0, 0);
        runTxn("sat27",       0, 1, 0, 1, 8'd27,  1, 5'd4, 0, 1, 0, 0);
        runTxn("sat255",      0, 0, 1, 0, 8'd255, 0, 5'd31, 0, 0, 0, 0);
        runTxn("zero_mant",   0, 0, 1, 1, 8'd5,   1, 5'd9, 1, 1, 0, 0);
        runTxn("mul_run1",    1, 1, 0, 0, 8'd0,   1, 5'd7, 0, 1, 1, 0);

        // asynchronous reset in MUL_RUN: outputs clear at once, no done afterwards
        @(negedge clk);
        op = 1; start = 1; multDone = 0;
        @(negedge clk); start = 0;
        repeat (3) @(negedge clk);
        #2 reset = 0;
        #1 check("rst_async", zero);
        @(negedge clk); check("rst_hold1", zero);
        @(negedge clk); check("rst_hold2", zero);
        reset = 1;
        @(negedge clk); check("rst_release", zero);
        runTxn("after_rst",   1, 0, 1, 0, 8'd0,   0, 5'd2, 0, 0, 3, 0);

        for (int k = 0; k < 40; k++) begin
            runTxn($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                   int'($urandom_range(1, 12)), 0);
        end

`ifdef FP_CTRL_TIMEOUT_EN
        runTxn("timeout",     1, 0, 0, 0, 8'd0,   0, 5'd0, 0, 0, 0, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
